mem_port_arbiter: RTL and testbench

Shares the single 64-bit memory port of the multicycle RISC-V core between two requesters: the instruction-fetch path and the load/store data path. It sequences each access through a fixed-latency memory, returns read data with a one-cycle acknowledge pulse, and resolves simultaneous requests round-robin. It sits between the control FSM / datapath and the unified memory, and replaces the separate instruction and data memory read strobes.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle between the fetch/data requesters, the arbiter
// and the unified memory.
//   slave  : arbiter view (samples requests and mem_rdata, drives acks and the memory strobes)
//   master : environment view (requesters plus memory)
interface mem_port_arbiter_if;
    // Instruction-fetch requester
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    // Load/store requester
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;
    // Unified memory
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_rdata;
    // Status
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata,
               mem_re, mem_we, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata,
               mem_re, mem_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency 64-bit memory port between
// the instruction-fetch and load/store paths.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : mem_port_arbiter_if.slave (requests/acks, memory strobes, busy)
// Parameter RD_LAT (1..8): cycles from the mem_re cycle to valid mem_rdata.
module mem_port_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned DW    = 64;
    localparam int unsigned IW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_e;

    state_e             state_q,     state_d;
    owner_e             owner_q,     owner_d;
    owner_e             last_q,      last_d;
    logic               we_q,        we_d;
    logic               half_q,      half_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [DW-1:0]      mem_addr_q,  mem_addr_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic               mem_re_q,    mem_re_d;
    logic               mem_we_q,    mem_we_d;
    logic               if_ack_q,    if_ack_d;
    logic               d_ack_q,     d_ack_d;
    logic [IW-1:0]      if_rdata_q,  if_rdata_d;
    logic [DW-1:0]      d_rdata_q,   d_rdata_d;
    logic               busy_q,      busy_d;
    logic               grant_data;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_FETCH;
            last_q      <= OWN_DATA;
            we_q        <= 1'b0;
            half_q      <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic; strobes and acks default low so they pulse
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_data  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    // On a tie the requester that did not win last time goes first
                    grant_data  = bus.d_req && (!bus.if_req || (last_q == OWN_FETCH));
                    owner_d     = grant_data ? OWN_DATA : OWN_FETCH;
                    last_d      = owner_d;
                    we_d        = grant_data && bus.d_we;
                    mem_addr_d  = (grant_data ? bus.d_addr : bus.if_addr) & ~DW'(7);
                    mem_wdata_d = bus.d_wdata;
                    half_d      = bus.if_addr[2];
                    // Strobes are registered here so they line up with ACCESS
                    mem_re_d    = !we_d;
                    mem_we_d    = we_d;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    d_ack_d  = (owner_q == OWN_DATA);
                    if_ack_d = (owner_q == OWN_FETCH);
                    state_d  = ST_RESP;
                end else begin
                    // WAIT spans exactly RD_LAT cycles; data is valid in its last one
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q == OWN_FETCH) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = half_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                    end else begin
                        d_ack_d    = 1'b1;
                        d_rdata_d  = bus.mem_rdata;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at RD_LAT 1, 3 and 4,
// each fed by a fixed-latency read-only memory model.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mem_port_arbiter_if b1 ();
    mem_port_arbiter_if b3 ();
    mem_port_arbiter_if b4 ();

    mem_port_arbiter #(.RD_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    mem_port_arbiter #(.RD_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
    mem_port_arbiter #(.RD_LAT(4)) u4 (.clk(clk), .reset(reset), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents, by doubleword address
    function automatic logic [63:0] mem_val(input logic [63:0] a);
        case (a)
            64'h100: mem_val = 64'hAAAABBBB_CCCCDDDD;
            64'h020: mem_val = 64'hDEADBEEF_01234567;
            64'h040: mem_val = 64'h01234567_89ABCDEF;
            64'h080: mem_val = 64'hFEDCBA98_76543210;
            default: mem_val = 64'hC0DE0000_00000000 | a;
        endcase
    endfunction

    // Read pipelines: data is valid RD_LAT cycles after the mem_re cycle, zero otherwise
    logic [63:0] pipe1;
    logic [63:0] pipe3 [3];
    logic [63:0] pipe4 [4];

    always @(posedge clk) begin
        pipe1    <= b1.mem_re ? mem_val(b1.mem_addr) : 64'h0;
        pipe3[0] <= b3.mem_re ? mem_val(b3.mem_addr) : 64'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        pipe4[0] <= b4.mem_re ? mem_val(b4.mem_addr) : 64'h0;
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
        pipe4[3] <= pipe4[2];
    end

    assign b1.mem_rdata = pipe1;
    assign b3.mem_rdata = pipe3[2];
    assign b4.mem_rdata = pipe4[3];

    task automatic idle_inputs();
        b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
        b4.if_req = 0; b4.if_addr = '0; b4.d_req = 0; b4.d_we = 0; b4.d_addr = '0; b4.d_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({b1.busy, b1.if_ack, b1.d_ack, b1.mem_re, b1.mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {b1.busy, b1.if_ack, b1.d_ack, b1.mem_re, b1.mem_we});
        end
        checks++;
        if ({b1.mem_addr, b1.mem_wdata} !== 128'h0) begin
            errors++; $display("FAIL reset_membus: got %h %h want 0", b1.mem_addr, b1.mem_wdata);
        end
        checks++;
        if ({b1.if_rdata, b1.d_rdata} !== 96'h0) begin
            errors++; $display("FAIL reset_rdata: got %h %h want 0", b1.if_rdata, b1.d_rdata);
        end
        checks++;
        if ({b3.busy, b4.busy, b3.mem_re, b4.mem_re} !== 4'b0) begin
            errors++; $display("FAIL reset_other: got %b want 0000", {b3.busy, b4.busy, b3.mem_re, b4.mem_re});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (b1.busy !== 1'b0) begin
            errors++; $display("FAIL idle_busy: got %b want 0", b1.busy);
        end
    endtask

    task automatic test_fetch();
        logic [63:0] addr_v [2];
        logic [31:0] exp_v [2];
        addr_v[0] = 64'h104; exp_v[0] = 32'hAAAABBBB;
        addr_v[1] = 64'h100; exp_v[1] = 32'hCCCCDDDD;
        for (int v = 0; v < 2; v++) begin
            int re_cyc, re_cnt, ack_cyc, ack_cnt;
            logic [63:0] re_addr;
            logic [31:0] rdata;
            re_cyc = -1; re_cnt = 0; ack_cyc = -1; ack_cnt = 0; re_addr = '1; rdata = '1;
            @(negedge clk);
            b1.if_addr = addr_v[v];
            b1.if_req  = 1'b1;
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk);
                if (b1.mem_re) begin re_cnt++; re_cyc = c; re_addr = b1.mem_addr; end
                if (b1.if_ack) begin ack_cnt++; ack_cyc = c; rdata = b1.if_rdata; b1.if_req = 1'b0; end
            end
            checks++;
            if (re_cyc != 1 || re_cnt != 1) begin
                errors++; $display("FAIL fetch_re: cycle %0d count %0d want cycle 1 count 1", re_cyc, re_cnt);
            end
            checks++;
            if (re_addr !== 64'h100) begin
                errors++; $display("FAIL fetch_addr: got %h want 100", re_addr);
            end
            checks++;
            if (ack_cyc != 3 || ack_cnt != 1) begin
                errors++; $display("FAIL fetch_ack: cycle %0d count %0d want cycle 3 count 1", ack_cyc, ack_cnt);
            end
            checks++;
            if (rdata !== exp_v[v]) begin
                errors++; $display("FAIL fetch_data: got %h want %h", rdata, exp_v[v]);
            end
        end
    endtask

    task automatic test_store();
        int we_cyc, we_cnt, re_cnt, ack_cyc;
        logic [63:0] we_addr, we_data;
        we_cyc = -1; we_cnt = 0; re_cnt = 0; ack_cyc = -1; we_addr = '1; we_data = '1;
        @(negedge clk);
        b1.d_we = 1'b1; b1.d_addr = 64'h13; b1.d_wdata = 64'h11223344_55667788; b1.d_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (b1.mem_re) re_cnt++;
            if (b1.mem_we) begin we_cnt++; we_cyc = c; we_addr = b1.mem_addr; we_data = b1.mem_wdata; end
            if (b1.d_ack) begin
                ack_cyc = c; b1.d_req = 1'b0;
                checks++;
                if (b1.d_rdata !== 64'h0) begin
                    errors++; $display("FAIL store_rdata_kept: got %h want 0", b1.d_rdata);
                end
            end
        end
        b1.d_we = 1'b0;
        checks++;
        if (we_cyc != 1 || we_cnt != 1) begin
            errors++; $display("FAIL store_we: cycle %0d count %0d want cycle 1 count 1", we_cyc, we_cnt);
        end
        checks++;
        if (we_addr !== 64'h10 || we_data !== 64'h11223344_55667788) begin
            errors++; $display("FAIL store_bus: got %h %h want 10 1122334455667788", we_addr, we_data);
        end
        checks++;
        if (ack_cyc != 2) begin
            errors++; $display("FAIL store_ack: got cycle %0d want 2", ack_cyc);
        end
        checks++;
        if (re_cnt != 0) begin
            errors++; $display("FAIL store_no_re: got %0d want 0", re_cnt);
        end
    endtask

    task automatic test_load_lat3();
        int re_cyc, ack_cyc;
        logic [8:0]  busy_mask;
        logic [63:0] rdata;
        re_cyc = -1; ack_cyc = -1; busy_mask = '0; rdata = '1;
        @(negedge clk);
        busy_mask[0] = b3.busy;
        b3.d_we = 1'b0; b3.d_addr = 64'h20; b3.d_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            busy_mask[c] = b3.busy;
            if (b3.mem_re) re_cyc = c;
            if (b3.d_ack) begin ack_cyc = c; rdata = b3.d_rdata; b3.d_req = 1'b0; end
        end
        checks++;
        if (re_cyc != 1) begin
            errors++; $display("FAIL load_re: got cycle %0d want 1", re_cyc);
        end
        checks++;
        if (ack_cyc != 5) begin
            errors++; $display("FAIL load_ack: got cycle %0d want 5", ack_cyc);
        end
        checks++;
        if (rdata !== 64'hDEADBEEF_01234567) begin
            errors++; $display("FAIL load_data: got %h want deadbeef01234567", rdata);
        end
        checks++;
        if (busy_mask !== 9'b000111110) begin
            errors++; $display("FAIL load_busy: got %b want 000111110", busy_mask);
        end
    endtask

    task automatic test_tie();
        int n_if, if1_cyc, if2_cyc, d_cyc;
        logic [31:0] if1_data, if2_data;
        logic [63:0] d_data;
        n_if = 0; if1_cyc = -1; if2_cyc = -1; d_cyc = -1; if1_data = '1; if2_data = '1; d_data = '1;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        b1.if_addr = 64'h44; b1.if_req = 1'b1;
        b1.d_we = 1'b0; b1.d_addr = 64'h80; b1.d_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2) b1.if_addr = 64'h40;
            if (b1.if_ack) begin
                n_if++;
                if (n_if == 1) begin if1_cyc = c; if1_data = b1.if_rdata; end
                else begin if2_cyc = c; if2_data = b1.if_rdata; b1.if_req = 1'b0; end
            end
            if (b1.d_ack) begin d_cyc = c; d_data = b1.d_rdata; b1.d_req = 1'b0; end
        end
        checks++;
        if (if1_cyc != 3 || if1_data !== 32'h01234567) begin
            errors++; $display("FAIL tie_fetch_first: cycle %0d data %h want cycle 3 data 01234567", if1_cyc, if1_data);
        end
        checks++;
        if (d_cyc != 7) begin
            errors++; $display("FAIL tie_data_next: got cycle %0d want 7", d_cyc);
        end
        checks++;
        if (d_data !== 64'hFEDCBA98_76543210) begin
            errors++; $display("FAIL tie_data_val: got %h want fedcba9876543210", d_data);
        end
        checks++;
        if (if2_cyc != 11 || if2_data !== 32'h89ABCDEF) begin
            errors++; $display("FAIL tie_fetch_again: cycle %0d data %h want cycle 11 data 89abcdef", if2_cyc, if2_data);
        end
    endtask

    task automatic test_back_to_back();
        int k, ovl, exp_cyc;
        logic exp_fetch;
        k = 0; ovl = 0;
        @(negedge clk);
        b3.if_addr = 64'h104; b3.if_req = 1'b1;
        b3.d_we = 1'b0; b3.d_addr = 64'h20; b3.d_req = 1'b1;
        for (int c = 1; c <= 50 && k < 6; c++) begin
            @(negedge clk);
            if (b3.mem_re && b3.mem_we) ovl++;
            if (b3.if_ack && b3.d_ack) ovl++;
            else if (b3.if_ack || b3.d_ack) begin
                exp_cyc   = 5 + 6 * k;
                exp_fetch = (k % 2 == 0);
                checks++;
                if (c != exp_cyc || b3.if_ack !== exp_fetch) begin
                    errors++; $display("FAIL b2b_order: ack %0d at cycle %0d fetch=%b want cycle %0d fetch=%b", k, c, b3.if_ack, exp_cyc, exp_fetch);
                end
                checks++;
                if (exp_fetch ? (b3.if_rdata !== 32'hAAAABBBB) : (b3.d_rdata !== 64'hDEADBEEF_01234567)) begin
                    errors++; $display("FAIL b2b_data: ack %0d got %h / %h", k, b3.if_rdata, b3.d_rdata);
                end
                k++;
                if (k == 6) begin b3.if_req = 1'b0; b3.d_req = 1'b0; end
            end
        end
        b3.if_req = 1'b0; b3.d_req = 1'b0;
        checks++;
        if (k != 6) begin
            errors++; $display("FAIL b2b_count: got %0d acks want 6", k);
        end
        checks++;
        if (ovl != 0) begin
            errors++; $display("FAIL b2b_overlap: got %0d want 0", ovl);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int re_cyc, ack_cnt, ack_cyc;
        logic [31:0] rdata;
        re_cyc = -1; ack_cnt = 0; ack_cyc = -1; rdata = '1;
        @(negedge clk);
        b4.if_addr = 64'h100; b4.if_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (b4.mem_re) re_cyc = c;
        end
        checks++;
        if (re_cyc != 1 || b4.busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre: re cycle %0d busy %b want 1 1", re_cyc, b4.busy);
        end
        reset = 1'b1; b4.if_req = 1'b0;
        #1;
        checks++;
        if ({b4.busy, b4.mem_re, b4.if_ack, b4.d_ack} !== 4'b0) begin
            errors++; $display("FAIL abort_async: got %b want 0000", {b4.busy, b4.mem_re, b4.if_ack, b4.d_ack});
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) reset = 1'b0;
            if (b4.if_ack) ack_cnt++;
        end
        checks++;
        if (ack_cnt != 0 || b4.busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_ack: acks %0d busy %b want 0 0", ack_cnt, b4.busy);
        end
        @(negedge clk);
        b4.if_addr = 64'h104; b4.if_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (b4.if_ack) begin ack_cyc = c; rdata = b4.if_rdata; b4.if_req = 1'b0; end
        end
        checks++;
        if (ack_cyc != 6 || rdata !== 32'hAAAABBBB) begin
            errors++; $display("FAIL post_reset_fetch: cycle %0d data %h want cycle 6 data aaaabbbb", ack_cyc, rdata);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fetch();
        test_store();
        test_load_lat3();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
